// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the read-mode encoding for the flexible synchronous FIFO.
package fifo_pkg;

   typedef enum logic {
      RD_FWFT = 1'b0,
      RD_REG  = 1'b1
   } read_mode_e;

   function automatic int ptr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic read_mode_e read_mode(input int fwft);
      return (fwft != 0) ? RD_FWFT : RD_REG;
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_sdp_ram #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 128,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with FWFT/registered read, threshold flags, flush,
// write-through-when-full and sticky overflow/underflow flags.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int NUM_ENTRIES = 64,
   parameter int DATA_W      = 128,
   parameter int FWFT        = 1,
   parameter int AF_THRESH   = NUM_ENTRIES - 4,
   parameter int AE_THRESH   = 4,
   localparam int AW         = ptr_w(NUM_ENTRIES),
   localparam int CW         = cnt_w(NUM_ENTRIES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   localparam read_mode_e      MODE    = read_mode(FWFT);
   localparam logic [AW-1:0]   LAST    = AW'(NUM_ENTRIES - 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(NUM_ENTRIES);
   localparam logic [CW-1:0]   AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0]   AE_C    = CW'(AE_THRESH);

   if (NUM_ENTRIES < 2) begin : g_bad_depth
      $error("sync_fifo_flex: NUM_ENTRIES must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > NUM_ENTRIES) begin : g_bad_af
      $error("sync_fifo_flex: AF_THRESH must be in 1..NUM_ENTRIES");
   end
   if (AE_THRESH < 0 || AE_THRESH > NUM_ENTRIES - 1) begin : g_bad_ae
      $error("sync_fifo_flex: AE_THRESH must be in 0..NUM_ENTRIES-1");
   end

   logic [AW-1:0]     w_ptr;
   logic [AW-1:0]     r_ptr;
   logic              rd_acc;
   logic              wr_acc;
   logic [DATA_W-1:0] ram_q;

   // Flags come only from the registered count, so no input reaches them combinationally.
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else begin
         if (wr_acc) w_ptr <= (w_ptr == LAST) ? '0 : w_ptr + 1'b1;
         if (rd_acc) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full, w_ptr == r_ptr: the popped word is read out before the edge overwrites it.
   fifo_sdp_ram #(
      .DEPTH  (NUM_ENTRIES),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc & ~flush),
      .waddr (w_ptr),
      .wdata (din),
      .raddr (r_ptr),
      .rdata (ram_q)
   );

   if (MODE == RD_FWFT) begin : g_fwft
      assign dout       = empty ? '0 : ram_q;
      assign dout_valid = ~empty;
   end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      logic              dout_valid_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
         end else if (flush) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
         end else begin
            if (rd_acc) dout_q <= ram_q;
            dout_valid_q <= rd_acc;
         end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
   end

   // A refusal in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & ~wr_acc & ~flush) overflow <= 1'b1;
         else if (err_clr)             overflow <= 1'b0;
         if (rd_en & ~rd_acc & ~flush) underflow <= 1'b1;
         else if (err_clr)             underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: an FWFT depth-8 instance and a registered-read depth-6 instance,
// each checked cycle by cycle against a queue-based reference model.
module tb_sync_fifo_flex;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] a_dout, b_dout;
   logic          a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic          b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [3:0]    a_count, b_count;

   logic [DW-1:0] o_dout;
   logic          o_dv, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
   logic [3:0]    o_count;
   logic          sel = 1'b0;

   int compared = 0;
   int mismatched = 0;

   int            m_depth, m_af, m_ae;
   bit            m_fwft;
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dreg;
   logic          m_dvld, m_ovf, m_unf;

   always #5 clk = ~clk;

   sync_fifo_flex #(
      .NUM_ENTRIES(8), .DATA_W(DW), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)
   ) u_a (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
      .err_clr(err_clr), .overflow(a_ovf), .underflow(a_unf)
   );

   sync_fifo_flex #(
      .NUM_ENTRIES(6), .DATA_W(DW), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)
   ) u_b (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
      .err_clr(err_clr), .overflow(b_ovf), .underflow(b_unf)
   );

   always_comb begin
      o_dout  = sel ? b_dout  : a_dout;
      o_dv    = sel ? b_dv    : a_dv;
      o_full  = sel ? b_full  : a_full;
      o_empty = sel ? b_empty : a_empty;
      o_af    = sel ? b_af    : a_af;
      o_ae    = sel ? b_ae    : a_ae;
      o_ovf   = sel ? b_ovf   : a_ovf;
      o_unf   = sel ? b_unf   : a_unf;
      o_count = sel ? b_count : a_count;
   end

   task automatic model_reset();
      mq.delete();
      m_dreg = '0;
      m_dvld = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // Applies the input values held across the edge that just happened.
   task automatic model_edge();
      bit ra, wa;
      if (flush) begin
         mq.delete();
         m_dvld = 1'b0;
         if (!m_fwft) m_dreg = '0;
         if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
      end else begin
         ra = rd_en && (mq.size() > 0);
         wa = wr_en && ((mq.size() < m_depth) || ra);
         if (ra) begin
            m_dreg = mq.pop_front();
            m_dvld = 1'b1;
         end else begin
            m_dvld = 1'b0;
         end
         if (wa) mq.push_back(din);
         if (wr_en && !wa) m_ovf = 1'b1;
         else if (err_clr) m_ovf = 1'b0;
         if (rd_en && !ra) m_unf = 1'b1;
         else if (err_clr) m_unf = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s (cfg %0d, t=%0t): observed %0h expected %0h", tag, sel, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      logic [DW-1:0] exp_dout;
      logic          exp_dv;
      n = mq.size();
      if (m_fwft) begin
         exp_dout = (n > 0) ? mq[0] : '0;
         exp_dv   = (n > 0);
      end else begin
         exp_dout = m_dreg;
         exp_dv   = m_dvld;
      end
      chk("count",        32'(o_count), 32'(n));
      chk("empty",        32'(o_empty), 32'(n == 0));
      chk("full",         32'(o_full),  32'(n == m_depth));
      chk("almost_full",  32'(o_af),    32'(n >= m_af));
      chk("almost_empty", 32'(o_ae),    32'(n <= m_ae));
      chk("dout",         32'(o_dout),  32'(exp_dout));
      chk("dout_valid",   32'(o_dv),    32'(exp_dv));
      chk("overflow",     32'(o_ovf),   32'(m_ovf));
      chk("underflow",    32'(o_unf),   32'(m_unf));
   endtask

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0);
      wr_en = w; din = d; rd_en = r; flush = f; err_clr = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      step(1'b0, '0, 1'b0);
   endtask

   task automatic run_config(input logic s, input int depth, input bit fwft);
      logic [DW-1:0] v;
      sel = s; m_depth = depth; m_fwft = fwft; m_af = 6; m_ae = 1;
      do_reset();

      // Fill with 1..depth then drain in order.
      for (int i = 1; i <= depth; i++) step(1'b1, DW'(i), 1'b0);
      for (int i = 0; i < depth; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Bursts of five to walk the pointers through the wrap point.
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
         for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      end
      step(1'b0, '0, 1'b0);

      // Simultaneous read/write while full: 0xAAAA lands at the tail.
      for (int i = 0; i < depth; i++) step(1'b1, DW'($urandom), 1'b0);
      step(1'b1, 16'hAAAA, 1'b1);
      for (int i = 0; i < depth; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Error flags: refused write, refused read, clear, clear racing a new refusal.
      for (int i = 0; i < depth; i++) step(1'b1, DW'($urandom), 1'b0);
      step(1'b1, 16'h5555, 1'b0);
      for (int i = 0; i < depth; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < depth; i++) step(1'b1, DW'($urandom), 1'b0);
      step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < depth; i++) step(1'b0, '0, 1'b1);

      // Flush with both requests active.
      for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
      step(1'b1, DW'($urandom), 1'b1, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset between edges with three entries held.
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      v = DW'($urandom);
      step(1'b1, v, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
   endtask

   initial begin
      model_reset();
      m_depth = 8; m_fwft = 1'b1; m_af = 6; m_ae = 1;
      run_config(1'b0, 8, 1'b1);
      run_config(1'b1, 6, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
